sweep_bist_engine: RTL



---
 rtl/bist_pkg.sv | 17 +
 rtl/misr_compactor.sv | 24 ++
 rtl/sweep_bist_engine.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and helpers for the exhaustive-sweep BIST engine.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;

    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shift Galois form
    localparam logic [15:0] DEF_POLY = 16'hB400;

    // Binary-reflected Gray code; callers truncate to their own width.
    function automatic logic [31:0] gray_enc(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/misr_compactor.sv
// Galois MISR: folds one response word per enabled cycle into a signature.
module misr_compactor #(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(bist_pkg::DEF_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    // Clear wins over a same-cycle update so a new run starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sig <= '0;
        else if (clear)
            sig <= '0;
        else if (en)
            sig <= (sig >> 1) ^ (sig[0] ? POLY : '0) ^ data;
    end

endmodule

// File: rtl/sweep_bist_engine.sv
// Exhaustive {b,a} sweep generator with MISR response compaction.
module sweep_bist_engine
    import bist_pkg::*;
#(
    parameter int               A_W      = 5,
    parameter int               B_W      = 5,
    parameter int               Y_W      = 3,
    parameter int               X_W      = 3,
    parameter int               PIPE_LAT = 0,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] POLY     = SIG_W'(DEF_POLY)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [SIG_W-1:0]   exp_sig,
    output logic [A_W-1:0]     a_out,
    output logic [B_W-1:0]     b_out,
    input  logic [Y_W-1:0]     y_in,
    input  logic [X_W-1:0]     xe_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [SIG_W-1:0]   signature,
    output logic [A_W+B_W:0]   vec_count
);

    localparam int N = A_W + B_W;
    // Low counter bits during the final DRAIN cycle (counter restarts at 2^N there).
    localparam logic [N-1:0] DRAIN_LAST = N'(PIPE_LAT - 1);

    bist_state_e     state_q, state_d;
    logic [N:0]      cnt_q, cnt_inc;
    logic [N-1:0]    vec_q, vec_nxt;
    logic            mode_q;
    logic            start_ok;
    logic [PIPE_LAT:0] vld_pipe;
    logic [SIG_W-1:0] resp;

    // MSB of cnt_inc rises exactly when the last vector has been issued.
    assign cnt_inc = cnt_q + (N+1)'(1);
    assign vec_nxt = (mode_q == MODE_GRAY) ? N'(gray_enc(32'(cnt_inc[N-1:0])))
                                           : cnt_inc[N-1:0];
    assign a_out   = vec_q[A_W-1:0];
    assign b_out   = vec_q[N-1:A_W];
    assign resp    = SIG_W'({xe_in, y_in});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and status decode.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        pass     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_inc[N]) state_d = (PIPE_LAT > 0) ? DRAIN : DONE;
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt_q[N-1:0] == DRAIN_LAST) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                pass = (signature == exp_sig);
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sweep counter, registered operand vector and latched mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            vec_q  <= '0;
            mode_q <= MODE_BIN;
        end else if (start_ok) begin
            cnt_q  <= '0;
            vec_q  <= '0;   // vector 0 is 0 in both orders
            mode_q <= mode;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_inc;
            if (!cnt_inc[N]) vec_q <= vec_nxt;   // hold last vector into DRAIN/DONE
        end else if (state_q == DRAIN) begin
            cnt_q <= cnt_inc;
        end
    end

    // Valid bits: stage 0 marks a live vector on a_out/b_out, stage PIPE_LAT its response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= start_ok || (state_q == RUN && !cnt_inc[N]);
            for (int i = 1; i <= PIPE_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Count of responses folded into the signature this run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  vec_count <= '0;
        else if (start_ok)           vec_count <= '0;
        else if (vld_pipe[PIPE_LAT]) vec_count <= vec_count + (N+1)'(1);
    end

    misr_compactor #(.SIG_W(SIG_W), .POLY(POLY)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_ok),
        .en    (vld_pipe[PIPE_LAT]),
        .data  (resp),
        .sig   (signature)
    );

endmodule
